// File: rtl/mem_patt_pkg.sv
// Shared definitions for the memory pattern generator/checker.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_patt_pkg;

    // Pattern mode encodings as seen on the mode input.
    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INDEX = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    // Test sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Fibonacci LFSR tap masks (bit i set = state bit i feeds the XOR).
    // Listed widths use maximal-length polynomials. Any other width falls
    // back to the top two bits, which still gives a usable
    // non-degenerate sequence.
    function automatic logic [63:0] lfsr_taps(input int w);
        logic [63:0] t;
        t = 64'd0;
        case (w)
            8:       t = 64'h0000_0000_0000_00B8;
            16:      t = 64'h0000_0000_0000_D008;
            24:      t = 64'h0000_0000_00E1_0000;
            32:      t = 64'h0000_0000_8020_0003;
            default: begin
                if (w >= 2 && w <= 64) begin
                    t = 64'd3 << (w - 2);
                end
            end
        endcase
        return t;
    endfunction

    // Pattern value selection. Walking-one and LFSR values come from the
    // generator's running state, so no modulo or divider is needed.
    function automatic logic [63:0] patt_fn(input logic [1:0]  mode,
                                            input logic [63:0] idx,
                                            input logic [63:0] state,
                                            input logic [63:0] const_p);
        logic [63:0] p;
        case (mode)
            MODE_CONST: p = const_p;
            MODE_INDEX: p = idx;
            default:    p = state;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mem_patt_gen.sv
// Registered pattern source: yields patt(0) after seed, patt(index_nxt) after step.
// Latency: 1 cycle from seed/step to the new pattern on patt.
// Backpressure: holds its output whenever neither seed nor step is asserted.
module mem_patt_gen
    import mem_patt_pkg::*;
#(
    parameter int                DATA_W     = 24,
    parameter int                CNT_W      = 19,
    parameter logic [DATA_W-1:0] CONST_PATT = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              seed,
    input  logic              step,
    input  logic [CNT_W-1:0]  index_nxt,
    output logic [DATA_W-1:0] patt
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] state_q, state_d;
    logic [DATA_W-1:0] patt_q, patt_d;
    logic [CNT_W-1:0]  idx_sel;

    // Advance walking-one / LFSR state and select the next pattern value.
    always_comb begin
        state_d = state_q;
        patt_d  = patt_q;
        idx_sel = index_nxt;
        if (seed) begin
            state_d = DATA_W'(1);
            idx_sel = '0;
        end else if (step) begin
            case (mode)
                MODE_WALK: state_d = {state_q[DATA_W-2:0], state_q[DATA_W-1]};
                MODE_LFSR: state_d = {state_q[DATA_W-2:0], ^(state_q & TAPS)};
                default:   state_d = state_q;
            endcase
        end
        if (seed || step) begin
            patt_d = DATA_W'(patt_fn(mode, 64'(idx_sel), 64'(state_d), 64'(CONST_PATT)));
        end
    end

    // Pattern and sequence state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= '0;
            patt_q  <= '0;
        end else begin
            state_q <= state_d;
            patt_q  <= patt_d;
        end
    end

    assign patt = patt_q;

endmodule

// File: rtl/mem_patt_chk.sv
// Frame-buffer pattern test: write one frame of pattern, read back and check it (optional MEM_PATT_CHK_ERR_CAPTURE_EN adds first-error capture).
// Latency: busy one cycle after start; results one cycle after the last read beat or timeout.
// Backpressure: write beats stall on wr_ready=0 with wr_data held; reads take rd_data_valid beats, starvation times out.
module mem_patt_chk
    import mem_patt_pkg::*;
#(
    parameter int                DATA_W      = 24,
    parameter int                FRAME_PIX   = 307200,
    parameter int                CNT_W       = 19,
    parameter logic [DATA_W-1:0] CONST_PATT  = DATA_W'(24'hFFFFFF),
    parameter int                TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_cnt
`ifdef MEM_PATT_CHK_ERR_CAPTURE_EN
    ,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp
`endif
);

    localparam int               TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;

    logic              wr_seed, wr_step, rd_seed, rd_step;
    logic [1:0]        wr_gen_mode;
    logic [DATA_W-1:0] rd_patt;
    logic              mismatch;

`ifdef MEM_PATT_CHK_ERR_CAPTURE_EN
    logic [CNT_W-1:0]  cap_idx_q, cap_idx_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic [DATA_W-1:0] cap_exp_q, cap_exp_d;
`endif

    assign mismatch    = (rd_data != rd_patt);
    // Write generator is seeded in the start cycle, before mode_q is loaded.
    assign wr_gen_mode = wr_seed ? mode : mode_q;

    // Sequencer: start handling, write beat acceptance, read compare and timeout.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        err_cnt_d = err_cnt_q;
        idle_d    = idle_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        wr_seed   = 1'b0;
        wr_step   = 1'b0;
        rd_seed   = 1'b0;
        rd_step   = 1'b0;
`ifdef MEM_PATT_CHK_ERR_CAPTURE_EN
        cap_idx_d  = cap_idx_q;
        cap_data_d = cap_data_q;
        cap_exp_d  = cap_exp_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_WRITE;
                    mode_d    = mode;
                    wr_idx_d  = '0;
                    rd_idx_d  = '0;
                    err_cnt_d = '0;
                    idle_d    = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    wr_seed   = 1'b1;
`ifdef MEM_PATT_CHK_ERR_CAPTURE_EN
                    cap_idx_d  = '0;
                    cap_data_d = '0;
                    cap_exp_d  = '0;
`endif
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    wr_step  = 1'b1;
                    wr_idx_d = wr_idx_q + CNT_W'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = ST_READ;
                        rd_seed  = 1'b1;
                        rd_idx_d = '0;
                        idle_d   = '0;
                    end
                end
            end
            ST_READ: begin
                if (rd_data_valid) begin
                    rd_step  = 1'b1;
                    rd_idx_d = rd_idx_q + CNT_W'(1);
                    idle_d   = '0;
                    if (mismatch) begin
`ifdef MEM_PATT_CHK_ERR_CAPTURE_EN
                        // err_cnt never returns to zero within a test, so zero marks the first miss.
                        if (err_cnt_q == '0) begin
                            cap_idx_d  = rd_idx_q;
                            cap_data_d = rd_data;
                            cap_exp_d  = rd_patt;
                        end
`endif
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        pass_d  = (err_cnt_d == '0);
                        fail_d  = (err_cnt_d != '0);
                    end
                end else if (idle_q == TO_LAST) begin
                    state_d   = ST_DONE;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, counters and sticky result flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            err_cnt_q <= '0;
            idle_q    <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            err_cnt_q <= err_cnt_d;
            idle_q    <= idle_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef MEM_PATT_CHK_ERR_CAPTURE_EN
    // First-mismatch capture registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_idx_q  <= '0;
            cap_data_q <= '0;
            cap_exp_q  <= '0;
        end else begin
            cap_idx_q  <= cap_idx_d;
            cap_data_q <= cap_data_d;
            cap_exp_q  <= cap_exp_d;
        end
    end

    assign first_err_idx  = cap_idx_q;
    assign first_err_data = cap_data_q;
    assign first_err_exp  = cap_exp_q;
`endif

    mem_patt_gen #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .CONST_PATT (CONST_PATT)
    ) u_wr_gen (
        .clk       (clk),
        .reset     (reset),
        .mode      (wr_gen_mode),
        .seed      (wr_seed),
        .step      (wr_step),
        .index_nxt (wr_idx_d),
        .patt      (wr_data)
    );

    mem_patt_gen #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .CONST_PATT (CONST_PATT)
    ) u_rd_gen (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode_q),
        .seed      (rd_seed),
        .step      (rd_step),
        .index_nxt (rd_idx_d),
        .patt      (rd_patt)
    );

    assign wr_valid = (state_q == ST_WRITE);
    assign busy     = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign timeout  = timeout_q;
    assign err_cnt  = err_cnt_q;

endmodule
